// File: rtl/ddr2_if_ex_rd_checker_if.sv
// ddr2_if_ex_rd_checker_if: read-beat and result bundle between the example driver and its read checker.
interface ddr2_if_ex_rd_checker_if #(
  parameter int DATA_BYTES = 4,
  parameter int CNT_W = 16,
  parameter int ERR_W = 16
);
  logic start;
  logic [CNT_W-1:0] num_words;
  logic rdata_valid;
  logic [8*DATA_BYTES-1:0] rdata;
  logic busy;
  logic done;
  logic pass;
  logic fail;
  logic [ERR_W-1:0] err_count;
  logic [DATA_BYTES-1:0] lane_err;
  logic [CNT_W-1:0] first_err_idx;
  logic [8*DATA_BYTES-1:0] expected;
  modport master (
    output start, num_words, rdata_valid, rdata,
    input busy, done, pass, fail, err_count, lane_err, first_err_idx, expected
  );
  modport slave (
    input start, num_words, rdata_valid, rdata,
    output busy, done, pass, fail, err_count, lane_err, first_err_idx, expected
  );
endinterface

// File: rtl/ddr2_if_ex_rd_checker.sv
// ddr2_if_ex_rd_checker: regenerates the per-lane LFSR write pattern and scores returned read beats.
module ddr2_if_ex_rd_checker #(
  parameter int DATA_BYTES = 4,
  parameter int SEED = 32,
  parameter int CNT_W = 16,
  parameter int ERR_W = 16
) (
  input logic clk,
  input logic reset_n,
  ddr2_if_ex_rd_checker_if.slave bus
);
  localparam int DW = 8 * DATA_BYTES;
  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;
  function automatic logic [DW-1:0] seed_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DATA_BYTES; i++) w[8*i +: 8] = 8'(SEED + i);
    return w;
  endfunction
  function automatic logic [7:0] lfsr_step(input logic [7:0] q);
    return {q[6], q[5], q[4], q[3] ^ q[7], q[2] ^ q[7], q[1] ^ q[7], q[0], q[7]};
  endfunction
  localparam logic [DW-1:0] SEED_WORD = seed_word();
  state_t state_q, state_d;
  logic [DW-1:0] lfsr_q, lfsr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] first_q, first_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [DATA_BYTES-1:0] lane_err_q, lane_err_d;
  logic [DATA_BYTES-1:0] mism;
  logic done_q, done_d;
  logic pass_q, pass_d;
  logic fail_q, fail_d;
  always_comb begin
    state_d = state_q;
    lfsr_d = lfsr_q;
    cnt_d = cnt_q;
    num_d = num_q;
    first_d = first_q;
    err_d = err_q;
    lane_err_d = lane_err_q;
    mism = '0;
    for (int i = 0; i < DATA_BYTES; i++) mism[i] = bus.rdata[8*i +: 8] != lfsr_q[8*i +: 8];
    if (bus.start) begin
      lfsr_d = SEED_WORD;
      cnt_d = '0;
      num_d = bus.num_words;
      first_d = '0;
      err_d = '0;
      lane_err_d = '0;
      state_d = bus.num_words == '0 ? DONE : CHECK;
    end else if (state_q == CHECK && bus.rdata_valid) begin
      for (int i = 0; i < DATA_BYTES; i++) lfsr_d[8*i +: 8] = lfsr_step(lfsr_q[8*i +: 8]);
      cnt_d = cnt_q + 1'b1;
      lane_err_d = lane_err_q | mism;
      // first_err_idx only latches on the beat that takes err_count off zero
      if (|mism) begin
        err_d = &err_q ? err_q : err_q + 1'b1;
        first_d = err_q == '0 ? cnt_q : first_q;
      end
      state_d = cnt_q == num_q - 1'b1 ? DONE : CHECK;
    end
    done_d = state_d == DONE;
    pass_d = done_d && err_d == '0;
    fail_d = done_d && err_d != '0;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      lfsr_q <= SEED_WORD;
      cnt_q <= '0;
      num_q <= '0;
      first_q <= '0;
      err_q <= '0;
      lane_err_q <= '0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q <= lfsr_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      first_q <= first_d;
      err_q <= err_d;
      lane_err_q <= lane_err_d;
      done_q <= done_d;
      pass_q <= pass_d;
      fail_q <= fail_d;
    end
  end
  assign bus.busy = state_q == CHECK;
  assign bus.done = done_q;
  assign bus.pass = pass_q;
  assign bus.fail = fail_q;
  assign bus.err_count = err_q;
  assign bus.lane_err = lane_err_q;
  assign bus.first_err_idx = first_q;
  assign bus.expected = lfsr_q;
endmodule

// File: doc/ddr2_if_ex_rd_checker.md
Name: ddr2_if_ex_rd_checker

Overview:
- Read-data checker for the DDR2 example driver. Consumes read beats returned from the memory interface.
- Regenerates the expected write pattern with per-byte-lane 8-bit LFSRs and compares every byte.
- Accumulates error statistics and reports pass/fail to the driver's test-control logic once a programmed number of beats has been checked.

Parameters:
- DATA_BYTES, 4, number of byte lanes; local data width is 8*DATA_BYTES.
- SEED, 32, base LFSR seed; lane i is seeded with (SEED + i) mod 256.
- CNT_W, 16, width of the beat counter, num_words and first_err_idx.
- ERR_W, 16, width of err_count.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; arms a new check run.
- num_words  in  CNT_W  number of beats to check; sampled on start.
- rdata_valid  in  1  read beat valid.
- rdata  in  8*DATA_BYTES  read data; lane i = rdata[8i+7:8i].
- busy  out  1  high while in CHECK.
- done  out  1  high in DONE until the next start.
- pass  out  1  done and err_count==0.
- fail  out  1  done and err_count!=0.
- err_count  out  ERR_W  number of beats with at least one mismatching lane; saturating.
- lane_err  out  DATA_BYTES  sticky per-lane mismatch flags.
- first_err_idx  out  CNT_W  beat index (0-based) of the first failing beat.
- expected  out  8*DATA_BYTES  current expected word, for debug.

Behaviour:
- Reset values:
  - State IDLE.
  - busy, done, pass, fail = 0.
  - err_count, lane_err, first_err_idx, beat counter = 0.
  - Lane i LFSR = (SEED+i)[7:0].
- LFSR step (per lane, q = current value, n = next value):
  - n0=q7; n1=q0; n2=q1^q7; n3=q2^q7; n4=q3^q7; n5=q4; n6=q5; n7=q6.
  - The step is identical to the write-side generator, so the expected stream matches the written stream beat for beat.
  - expected = concatenation of lane LFSRs, lane 0 in the LSBs.
- States:
  - IDLE: wait for start.
  - CHECK: compare incoming beats.
  - DONE: hold results.
- start (in any state):
  - At the edge, reload all LFSRs to seed, clear err_count, lane_err, first_err_idx and the beat counter, and latch num_words.
  - If num_words==0, go to DONE (pass=1). Otherwise go to CHECK.
  - start overrides a coincident rdata_valid; that beat is not checked.
- CHECK, on a beat with rdata_valid=1:
  - Compute the lane mismatch vector m[i] = (rdata lane i != expected lane i) against the current LFSR values.
  - At the same edge:
    - All LFSRs step.
    - The beat counter increments.
    - lane_err |= m.
    - If m!=0: err_count increments, saturating at all-ones. If err_count was 0 before this beat, first_err_idx = the beat counter value before the increment.
- CHECK, on a cycle with rdata_valid=0: nothing changes; the LFSRs hold (pause semantics).
- Run completion: when the accepted beat is beat number num_words-1, the FSM enters DONE at that same edge.
  - done, pass and fail are registered and reflect that beat's result from the following cycle onward.
  - Latency: each beat's result is visible in the counters one clock after it is accepted.
- DONE:
  - rdata_valid is ignored.
  - Outputs hold until the next start.
- IDLE: rdata_valid is ignored.
- Derived outputs:
  - busy = (state==CHECK).
  - pass and fail are mutually exclusive and both 0 outside DONE.
- Reset mid-run: all state and outputs return asynchronously to their reset values. No partial result is retained.

Test Plan:
- Reset, DATA_BYTES=2, start with num_words=4, then four consecutive valid beats 0x2120, 0x4240, 0x8480, 0x151D -> busy 1 for 4 cycles, then done=1, pass=1, err_count=0, lane_err=00.
- Same stream with beat 2 = 0x8481 -> lane_err=01, err_count=1, first_err_idx=2, fail=1.
- Same stream with rdata_valid gaps of 3 idle cycles between beats -> identical pass result; expected holds during the gaps.
- start with num_words=0 -> done and pass on the next cycle; busy never asserts.
- start asserted again after beat 1 of a run that had an error -> counters clear, LFSRs reseed; a correct 4-beat stream then gives pass=1.
- reset_n pulsed low after beat 2 of a run -> busy=0, err_count=0, state IDLE, expected=0x2120; subsequent beats are ignored until start.
